// File: rtl/clipper_window_ctrl.sv
// rtl/clipper_window_ctrl.sv - clipper window sequencer with frame-boundary commit of window coefficients
//
// Purpose: owns the clipper window path enable and the top/left/width/height
// coefficients. Window requests arrive over a valid/ready port, are validated,
// held in a shadow copy and committed only at a frame boundary (active vsync
// edge), so a frame never mixes two windows. While the path is idle a request
// commits on the cycle after it is accepted.
//
// Optional feature: define WIN_CTRL_CLAMP_EN to clamp windows that overhang the
// right/bottom frame edge instead of rejecting them.
//
// Ports:
//   pclk        in   1   pixel clock, rising edge
//   prst        in   1   synchronous reset, active-high
//   run         in   1   1 = path running, 0 = stop at next frame boundary
//   cfg_valid   in   1   window request valid
//   cfg_ready   out  1   request accepted when cfg_valid & cfg_ready
//   cfg_top     in   12  requested top
//   cfg_left    in   12  requested left
//   cfg_width   in   12  requested width
//   cfg_height  in   12  requested height
//   vs_in       in   1   vsync returned from the window path
//   win_enable  out  1   enable to the window path
//   top/left    out  12  committed coefficients
//   width/height out 12  committed coefficients
//   pending     out  1   shadow holds an uncommitted request
//   cfg_err     out  1   one-cycle pulse: request rejected
//   frame_cnt   out  16  frames since win_enable rose, wrapping

module clipper_window_ctrl #(
    parameter int HACT   = 1920,
    parameter int VACT   = 1080,
    parameter bit VS_POL = 1'b1
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        run,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [11:0] cfg_top,
    input  logic [11:0] cfg_left,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    input  logic        vs_in,
    output logic        win_enable,
    output logic [11:0] top,
    output logic [11:0] left,
    output logic [11:0] width,
    output logic [11:0] height,
    output logic        pending,
    output logic        cfg_err,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [12:0] HACT_X = 13'(HACT);
    localparam logic [12:0] VACT_X = 13'(VACT);

    logic [1:0]  state;
    logic        vs_q;
    logic        vs_act;
    logic        vs_q_act;
    logic        bnd;

    logic [11:0] sh_top;
    logic [11:0] sh_left;
    logic [11:0] sh_width;
    logic [11:0] sh_height;

    logic        accept;
    logic        req_bad;
    logic        zero_bad;
    logic        origin_bad;
    logic        h_ovf;
    logic        v_ovf;
    logic [12:0] right_x;
    logic [12:0] bottom_x;
    logic [11:0] width_fix;
    logic [11:0] height_fix;
    logic        do_commit;

    // Boundary is the inactive->active transition of vsync; the previous
    // sample lives in vs_q, so bnd is high for exactly one cycle per frame.
    assign vs_act   = (vs_in == VS_POL);
    assign vs_q_act = (vs_q == VS_POL);
    assign bnd      = vs_act & ~vs_q_act;

    assign cfg_ready  = ~pending;
    assign accept     = cfg_valid & cfg_ready;
    assign win_enable = (state != ST_IDLE);

    // 13-bit sums so a 12-bit origin plus a 12-bit size cannot wrap.
    assign right_x    = {1'b0, cfg_left} + {1'b0, cfg_width};
    assign bottom_x   = {1'b0, cfg_top} + {1'b0, cfg_height};
    assign zero_bad   = (cfg_width == 12'd0) | (cfg_height == 12'd0);
    assign origin_bad = ({1'b0, cfg_left} >= HACT_X) | ({1'b0, cfg_top} >= VACT_X);
    assign h_ovf      = (right_x > HACT_X);
    assign v_ovf      = (bottom_x > VACT_X);

`ifdef WIN_CTRL_CLAMP_EN
    logic [12:0] width_clip;
    logic [12:0] height_clip;

    // Origin is known to be inside the frame whenever the clip is used,
    // so these differences are positive and fit in 12 bits.
    assign width_clip  = HACT_X - {1'b0, cfg_left};
    assign height_clip = VACT_X - {1'b0, cfg_top};
    assign req_bad     = zero_bad | origin_bad;
    assign width_fix   = h_ovf ? width_clip[11:0] : cfg_width;
    assign height_fix  = v_ovf ? height_clip[11:0] : cfg_height;
`else
    assign req_bad     = zero_bad | origin_bad | h_ovf | v_ovf;
    assign width_fix   = cfg_width;
    assign height_fix  = cfg_height;
`endif

    // Idle commits immediately; otherwise only on a boundary. A START that is
    // abandoned by run=0 leaves the shadow pending for the idle commit.
    assign do_commit = pending &
                       ((state == ST_IDLE) |
                        (bnd & ~((state == ST_START) & ~run)));

    always_ff @(posedge pclk) begin
        vs_q <= vs_in;
        if (prst) begin
            state     <= ST_IDLE;
            top       <= 12'd0;
            left      <= 12'd0;
            width     <= 12'(HACT);
            height    <= 12'(VACT);
            sh_top    <= 12'd0;
            sh_left   <= 12'd0;
            sh_width  <= 12'd0;
            sh_height <= 12'd0;
            pending   <= 1'b0;
            cfg_err   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            cfg_err <= 1'b0;

            // accept implies !pending, so this never races with do_commit.
            if (accept) begin
                if (req_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    sh_top    <= cfg_top;
                    sh_left   <= cfg_left;
                    sh_width  <= width_fix;
                    sh_height <= height_fix;
                    pending   <= 1'b1;
                end
            end

            if (do_commit) begin
                top     <= sh_top;
                left    <= sh_left;
                width   <= sh_width;
                height  <= sh_height;
                pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state     <= ST_START;
                        frame_cnt <= 16'd0;
                    end
                end
                ST_START: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (bnd) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bnd) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                    if (!run) begin
                        state <= ST_STOP;
                    end
                end
                default: begin
                    if (bnd) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
